imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_if.sv | 25 ++
 rtl/imm_gen_pipe.sv | 133 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_if.sv
// Decode-to-execute immediate bus: valid/ready input side, flush, and the registered output entry.
interface imm_gen_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [2:0]      imm_sel;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm;
    logic [2:0]      out_sel;
    logic            illegal;

    modport master (
        output in_valid, instr, imm_sel, flush, out_ready,
        input  in_ready, out_valid, imm, out_sel, illegal
    );

    modport slave (
        input  in_valid, instr, imm_sel, flush, out_ready,
        output in_ready, out_valid, imm, out_sel, illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate expansion with a two-entry (output + skid) registered pipeline stage
// and a saturating counter of accepted reserved-select entries.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    imm_gen_if.slave         bus,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      sel;
        logic            illegal;
    } entry_t;

    localparam logic [2:0] SEL_I     = 3'b000;
    localparam logic [2:0] SEL_B     = 3'b001;
    localparam logic [2:0] SEL_J     = 3'b010;
    localparam logic [2:0] SEL_S     = 3'b011;
    localparam logic [2:0] SEL_U     = 3'b100;
    localparam logic [2:0] SEL_Z     = 3'b101;
    localparam logic [2:0] SEL_SHAMT = 3'b110;
    localparam logic [2:0] SEL_RSVD  = 3'b111;

    entry_t           out_q, out_d;
    entry_t           skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    entry_t           new_entry_c;
    logic             accept_c;
    logic             consume_c;
    logic [31:0]      ins;
    logic             s;
    logic             unused_instr_bits;

    assign ins               = bus.instr;
    assign s                 = ins[31];
    assign unused_instr_bits = ^ins[6:0];

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // Combinational expansion of the presented instruction
    always_comb begin
        new_entry_c         = '0;
        new_entry_c.sel     = bus.imm_sel;
        new_entry_c.illegal = 1'b0;
        case (bus.imm_sel)
            SEL_I:     new_entry_c.imm = sext32({{20{s}}, ins[31:20]});
            SEL_S:     new_entry_c.imm = sext32({{20{s}}, ins[31:25], ins[11:7]});
            SEL_B:     new_entry_c.imm = sext32({{19{s}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
            SEL_J:     new_entry_c.imm = sext32({{11{s}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
            SEL_U:     new_entry_c.imm = sext32({ins[31:12], 12'b0});
            SEL_Z:     new_entry_c.imm = XLEN'(ins[19:15]);
            SEL_SHAMT: new_entry_c.imm = (XLEN == 64) ? XLEN'(ins[25:20]) : XLEN'(ins[24:20]);
            SEL_RSVD: begin
                new_entry_c.imm     = '0;
                new_entry_c.illegal = 1'b1;
            end
            default:   new_entry_c.imm = '0;
        endcase
    end

    assign accept_c  = bus.in_valid & in_ready_q & ~bus.flush;
    assign consume_c = out_valid_q & bus.out_ready;

    // Next-state for output/skid slots; skid only fills when output is held
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        cnt_d        = cnt_q;

        if (bus.flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (consume_c || !out_valid_q) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept_c) begin
                out_d       = new_entry_c;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept_c) begin
            skid_d       = new_entry_c;
            skid_valid_d = 1'b1;
        end

        if (accept_c && new_entry_c.illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            cnt_q        <= '0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.imm       = out_q.imm;
    assign bus.out_sel   = out_q.sel;
    assign bus.illegal   = out_q.illegal;
    assign illegal_cnt   = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: formats at XLEN=32/64, backpressure, flush, saturation, async reset.
module tb_imm_gen_pipe;

    logic       clk;
    logic       rst;
    logic [7:0] cnt32;
    logic [7:0] cnt64;
    logic [7:0] exp_cnt;
    int         checks;
    int         errors;

    imm_gen_if #(.XLEN(32)) bus32 ();
    imm_gen_if #(.XLEN(64)) bus64 ();

    imm_gen_pipe #(.XLEN(32), .CNT_W(8)) dut32 (
        .clk(clk), .rst(rst), .bus(bus32.slave), .illegal_cnt(cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(8)) dut64 (
        .clk(clk), .rst(rst), .bus(bus64.slave), .illegal_cnt(cnt64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus32.out_valid); end
        checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus32.in_ready); end
        checks++; if (bus32.imm !== 32'h0) begin errors++; $display("FAIL reset_imm got %h want 0", bus32.imm); end
        checks++; if (bus32.out_sel !== 3'b000) begin errors++; $display("FAIL reset_out_sel got %b want 000", bus32.out_sel); end
        checks++; if (bus32.illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", bus32.illegal); end
        checks++; if (cnt32 !== 8'd0) begin errors++; $display("FAIL reset_illegal_cnt got %0d want 0", cnt32); end
        checks++; if (bus64.imm !== 64'h0) begin errors++; $display("FAIL reset_imm64 got %h want 0", bus64.imm); end
    endtask

    task automatic test_formats32();
        logic [31:0] v_instr [8];
        logic [2:0]  v_sel   [8];
        logic [31:0] v_imm   [8];
        v_instr = '{32'hFFF00093, 32'hFE000EE3, 32'h123450B7, 32'hFE112E23,
                    32'h0080006F, 32'h000FD073, 32'h03F0D093, 32'hFFFFFFFF};
        v_sel   = '{3'd0, 3'd1, 3'd4, 3'd3, 3'd2, 3'd5, 3'd6, 3'd7};
        v_imm   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'hFFFFFFFC,
                    32'h00000008, 32'h0000001F, 32'h0000001F, 32'h00000000};
        bus32.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus32.in_valid = 1'b1;
            bus32.instr    = v_instr[i];
            bus32.imm_sel  = v_sel[i];
            step();
            if (v_sel[i] == 3'd7) exp_cnt = exp_cnt + 8'd1;
            checks++; if (bus32.out_valid !== 1'b1) begin errors++; $display("FAIL fmt%0d_out_valid got %b want 1", i, bus32.out_valid); end
            checks++; if (bus32.imm !== v_imm[i]) begin errors++; $display("FAIL fmt%0d_imm got %h want %h", i, bus32.imm, v_imm[i]); end
            checks++; if (bus32.out_sel !== v_sel[i]) begin errors++; $display("FAIL fmt%0d_out_sel got %b want %b", i, bus32.out_sel, v_sel[i]); end
            checks++; if (bus32.illegal !== (v_sel[i] == 3'd7)) begin errors++; $display("FAIL fmt%0d_illegal got %b want %b", i, bus32.illegal, v_sel[i] == 3'd7); end
            checks++; if (cnt32 !== exp_cnt) begin errors++; $display("FAIL fmt%0d_illegal_cnt got %0d want %0d", i, cnt32, exp_cnt); end
        end
        bus32.in_valid = 1'b0;
        step();
        checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL fmt_drain_out_valid got %b want 0", bus32.out_valid); end
    endtask

    task automatic test_xlen64();
        logic [31:0] v_instr [3];
        logic [2:0]  v_sel   [3];
        logic [63:0] v_imm   [3];
        v_instr = '{32'h800000B7, 32'h03F0D093, 32'hFFF00093};
        v_sel   = '{3'd4, 3'd6, 3'd0};
        v_imm   = '{64'hFFFFFFFF80000000, 64'h000000000000003F, 64'hFFFFFFFFFFFFFFFF};
        bus64.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus64.in_valid = 1'b1;
            bus64.instr    = v_instr[i];
            bus64.imm_sel  = v_sel[i];
            step();
            checks++; if (bus64.out_valid !== 1'b1) begin errors++; $display("FAIL x64_%0d_out_valid got %b want 1", i, bus64.out_valid); end
            checks++; if (bus64.imm !== v_imm[i]) begin errors++; $display("FAIL x64_%0d_imm got %h want %h", i, bus64.imm, v_imm[i]); end
        end
        bus64.in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        bus32.out_ready = 1'b0;
        bus32.in_valid  = 1'b1;
        bus32.imm_sel   = 3'd0;
        bus32.instr     = 32'h00100093;
        step();
        checks++; if (bus32.imm !== 32'd1 || bus32.out_valid !== 1'b1) begin errors++; $display("FAIL bp_A_loaded got v=%b imm=%h want v=1 imm=1", bus32.out_valid, bus32.imm); end
        checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL bp_A_in_ready got %b want 1", bus32.in_ready); end
        bus32.instr = 32'h00200093;
        step();
        checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("FAIL bp_B_in_ready got %b want 0", bus32.in_ready); end
        checks++; if (bus32.imm !== 32'd1) begin errors++; $display("FAIL bp_hold_A got %h want 1", bus32.imm); end
        bus32.instr = 32'h00300093;
        step();
        checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("FAIL bp_C_in_ready got %b want 0", bus32.in_ready); end
        checks++; if (bus32.imm !== 32'd1) begin errors++; $display("FAIL bp_hold_A2 got %h want 1", bus32.imm); end
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        step();
        checks++; if (bus32.out_valid !== 1'b1 || bus32.imm !== 32'd2) begin errors++; $display("FAIL bp_B_delivered got v=%b imm=%h want v=1 imm=2", bus32.out_valid, bus32.imm); end
        checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_back got %b want 1", bus32.in_ready); end
        step();
        checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL bp_C_not_taken got out_valid=%b imm=%h want out_valid=0", bus32.out_valid, bus32.imm); end
    endtask

    task automatic test_flush();
        bus32.out_ready = 1'b0;
        bus32.in_valid  = 1'b1;
        bus32.imm_sel   = 3'd0;
        bus32.instr     = 32'h00100093;
        step();
        bus32.instr = 32'h00200093;
        step();
        checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_full got in_ready=%b want 0", bus32.in_ready); end
        bus32.flush   = 1'b1;
        bus32.imm_sel = 3'd7;
        bus32.instr   = 32'h00400093;
        step();
        checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", bus32.out_valid); end
        checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b want 1", bus32.in_ready); end
        checks++; if (cnt32 !== exp_cnt) begin errors++; $display("FAIL flush_illegal_cnt got %0d want %0d", cnt32, exp_cnt); end
        bus32.flush     = 1'b0;
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        step();
        checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL flush_nothing_delivered got %b want 0", bus32.out_valid); end
    endtask

    task automatic test_illegal_sat();
        bus32.out_ready = 1'b1;
        bus32.in_valid  = 1'b1;
        bus32.imm_sel   = 3'd7;
        bus32.instr     = 32'hFFFFFFFF;
        for (int i = 0; i < 256; i++) begin
            step();
            exp_cnt = (exp_cnt == 8'd255) ? 8'd255 : exp_cnt + 8'd1;
            checks++; if (bus32.imm !== 32'h0 || bus32.illegal !== 1'b1 || bus32.out_valid !== 1'b1) begin errors++; $display("FAIL ill%0d_entry got v=%b imm=%h illegal=%b want v=1 imm=0 illegal=1", i, bus32.out_valid, bus32.imm, bus32.illegal); end
            checks++; if (cnt32 !== exp_cnt) begin errors++; $display("FAIL ill%0d_cnt got %0d want %0d", i, cnt32, exp_cnt); end
        end
        checks++; if (cnt32 !== 8'd255) begin errors++; $display("FAIL ill_saturated got %0d want 255", cnt32); end
        bus32.in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        bus32.out_ready = 1'b0;
        bus32.in_valid  = 1'b1;
        bus32.imm_sel   = 3'd0;
        bus32.instr     = 32'h00100093;
        step();
        bus32.instr = 32'h00200093;
        step();
        checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("FAIL rmid_skid_full got in_ready=%b want 0", bus32.in_ready); end
        #3;
        rst = 1'b1;
        #1;
        exp_cnt = 8'd0;
        checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b want 0", bus32.out_valid); end
        checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b want 1", bus32.in_ready); end
        checks++; if (bus32.imm !== 32'h0 || bus32.out_sel !== 3'b000 || bus32.illegal !== 1'b0) begin errors++; $display("FAIL rmid_payload got imm=%h sel=%b ill=%b want 0/000/0", bus32.imm, bus32.out_sel, bus32.illegal); end
        checks++; if (cnt32 !== 8'd0) begin errors++; $display("FAIL rmid_cnt got %0d want 0", cnt32); end
        step();
        checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_accept_in_reset got %b want 0", bus32.out_valid); end
        rst             = 1'b0;
        bus32.out_ready = 1'b1;
        bus32.imm_sel   = 3'd4;
        bus32.instr     = 32'h123450B7;
        step();
        checks++; if (bus32.out_valid !== 1'b1 || bus32.imm !== 32'h12345000 || bus32.out_sel !== 3'd4) begin errors++; $display("FAIL rmid_first_accept got v=%b imm=%h sel=%b want v=1 imm=12345000 sel=100", bus32.out_valid, bus32.imm, bus32.out_sel); end
        bus32.in_valid = 1'b0;
        step();
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        exp_cnt         = 8'd0;
        rst             = 1'b1;
        bus32.in_valid  = 1'b0;
        bus32.instr     = 32'h0;
        bus32.imm_sel   = 3'd0;
        bus32.flush     = 1'b0;
        bus32.out_ready = 1'b0;
        bus64.in_valid  = 1'b0;
        bus64.instr     = 32'h0;
        bus64.imm_sel   = 3'd0;
        bus64.flush     = 1'b0;
        bus64.out_ready = 1'b0;
        step();
        step();
        test_reset();
        rst = 1'b0;
        test_formats32();
        test_xlen64();
        test_backpressure();
        test_flush();
        test_illegal_sat();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
